// File: rtl/relm_i2c_target.sv
// ReLM I2C target: a small byte register file shared between an I2C
// bus and a core pop port.
module relm_i2c_target #(
    parameter int         WD       = 32,
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         WRA      = 4
) (
    input  logic        clk,
    input  logic        rst_n_in,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe_out,
    input  logic [WD:0] d_in,
    output logic [WD:0] q_out
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [2:0]     scl_sync;
    logic [2:0]     sda_sync;
    logic           scl;
    logic           sda;
    logic           scl_rise;
    logic           scl_fall;
    logic           start;
    logic           stop;
    logic [3:0]     bcnt;
    logic [3:0]     bcnt_nx;
    logic [6:0]     shreg;
    logic [6:0]     shreg_nx;
    logic [7:0]     byte_in;
    logic [7:0]     tx;
    logic [7:0]     tx_nx;
    logic [2:0]     tx_idx;
    logic           rw;
    logic           rw_nx;
    logic           match;
    logic           match_nx;
    logic           oe;
    logic           oe_nx;
    logic           commit;
    logic [WRA-1:0] ptr;
    logic [WRA-1:0] ptr_nx;
    logic [WRA-1:0] core_idx;
    logic           core_we;
    logic           core_clr;
    logic           wev;
    logic           busy;
    logic           unused_d;
    logic [7:0]     regs [2**WRA];

    assign core_we  = d_in[WD];
    assign core_clr = d_in[WD-2];
    assign core_idx = d_in[8 +: WRA];
    assign unused_d = ^{d_in[WD-1], d_in[WD-3:8+WRA]};

    // [0],[1] synchronize, [2] holds the previous synchronized value
    always_ff @(posedge clk) begin
        if (!rst_n_in) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[1:0], scl_in};
            sda_sync <= {sda_sync[1:0], sda_in};
        end
    end

    assign scl      = scl_sync[1];
    assign sda      = sda_sync[1];
    assign scl_rise = scl & ~scl_sync[2];
    assign scl_fall = ~scl & scl_sync[2];
    assign start    = scl & scl_sync[2] & ~sda & sda_sync[2];
    assign stop     = scl & scl_sync[2] & sda & ~sda_sync[2];
    assign byte_in  = {shreg, sda};
    assign tx_idx   = 3'(4'd7 - bcnt);

    always_comb begin
        state_nx = state;
        bcnt_nx  = bcnt;
        shreg_nx = shreg;
        tx_nx    = tx;
        rw_nx    = rw;
        match_nx = match;
        ptr_nx   = ptr;
        oe_nx    = oe;
        commit   = 1'b0;
        if (start) begin
            state_nx = ADDR;
            bcnt_nx  = '0;
            oe_nx    = 1'b0;
        end else if (stop) begin
            state_nx = IDLE;
            oe_nx    = 1'b0;
        end else begin
            unique case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && bcnt != 4'd8) begin
                        shreg_nx = byte_in[6:0];
                        bcnt_nx  = bcnt + 4'd1;
                        if (bcnt == 4'd7) begin
                            unique case (1'b1)
                                state == ADDR: begin
                                    match_nx = byte_in[7:1] == DEV_ADDR;
                                    rw_nx    = byte_in[0];
                                end
                                state == PTR: begin
                                    ptr_nx = byte_in[WRA-1:0];
                                end
                                default: begin
                                    commit = 1'b1;
                                    ptr_nx = ptr + WRA'(1);
                                end
                            endcase
                        end
                    end else if (scl_fall && bcnt == 4'd8) begin
                        if (state == ADDR && !match) begin
                            state_nx = WAIT;
                        end else begin
                            oe_nx = 1'b1;
                            unique case (1'b1)
                                state == ADDR: state_nx = ADDR_ACK;
                                state == PTR:  state_nx = PTR_ACK;
                                default:       state_nx = WDATA_ACK;
                            endcase
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            // first read bit goes out on the ACK's falling edge
                            tx_nx    = regs[ptr];
                            oe_nx    = ~regs[ptr][7];
                            bcnt_nx  = 4'd1;
                            state_nx = RDATA;
                        end else begin
                            oe_nx    = 1'b0;
                            bcnt_nx  = '0;
                            state_nx = PTR;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        oe_nx    = 1'b0;
                        bcnt_nx  = '0;
                        state_nx = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bcnt == 4'd8) begin
                            oe_nx    = 1'b0;
                            ptr_nx   = ptr + WRA'(1);
                            state_nx = RDATA_ACK;
                        end else begin
                            oe_nx   = ~tx[tx_idx];
                            bcnt_nx = bcnt + 4'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda) begin
                            tx_nx    = regs[ptr];
                            bcnt_nx  = '0;
                            state_nx = RDATA;
                        end else begin
                            state_nx = WAIT;
                        end
                    end
                end
                IDLE, WAIT: begin
                end
                default: begin
                    state_nx = IDLE;
                    oe_nx    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n_in) begin
            state <= IDLE;
            bcnt  <= '0;
            shreg <= '0;
            tx    <= '0;
            rw    <= 1'b0;
            match <= 1'b0;
            ptr   <= '0;
            oe    <= 1'b0;
            wev   <= 1'b0;
        end else begin
            state <= state_nx;
            bcnt  <= bcnt_nx;
            shreg <= shreg_nx;
            tx    <= tx_nx;
            rw    <= rw_nx;
            match <= match_nx;
            ptr   <= ptr_nx;
            oe    <= oe_nx;
            if (commit) begin
                wev <= 1'b1;
            end else if (core_clr) begin
                wev <= 1'b0;
            end
        end
    end

    // core write is issued last so it overrides a same-index bus commit
    always_ff @(posedge clk) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 2**WRA; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (commit) begin
                regs[ptr] <= byte_in;
            end
            if (core_we) begin
                regs[core_idx] <= d_in[7:0];
            end
        end
    end

    assign busy       = (state != IDLE) && (state != WAIT);
    assign sda_oe_out = oe;

    always_comb begin
        q_out             = '0;
        q_out[WD-1]       = busy;
        q_out[WD-2]       = wev;
        q_out[8 +: WRA]   = ptr;
        q_out[7:0]        = regs[core_idx];
    end

endmodule

// File: tb/tb_relm_i2c_target.sv
// Directed bench for relm_i2c_target: core-port vector table plus
// bit-level I2C master sequences.
module tb_relm_i2c_target;

    localparam int WD = 32;

    typedef struct {
        logic        we;
        logic        clr;
        logic [3:0]  idx;
        logic [7:0]  data;
        logic [WD:0] exp_q;
    } vec_t;

    logic        clk;
    logic        rst_n_in;
    logic        scl_m;
    logic        sda_m;
    logic        sda_bus;
    logic        sda_oe_out;
    logic [WD:0] d_in;
    logic [WD:0] q_out;
    int          checks;
    int          fails;
    vec_t        tbl [10];
    logic [7:0]  rd;

    relm_i2c_target #(
        .WD(WD),
        .DEV_ADDR(7'h42),
        .WRA(4)
    ) dut (
        .clk(clk),
        .rst_n_in(rst_n_in),
        .scl_in(scl_m),
        .sda_in(sda_bus),
        .sda_oe_out(sda_oe_out),
        .d_in(d_in),
        .q_out(q_out)
    );

    assign sda_bus = sda_m & ~sda_oe_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WD:0] mkd(logic we, logic clr,
                                        logic [3:0] idx, logic [7:0] data);
        return {we, 1'b0, clr, 18'd0, idx, data};
    endfunction

    function automatic logic [WD:0] mkq(logic busy, logic wev,
                                        logic [3:0] ptr, logic [7:0] data);
        return {1'b0, busy, wev, 18'd0, ptr, data};
    endfunction

    task automatic check(input string name, input logic [WD:0] act,
                         input logic [WD:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_q(input string name, input logic [3:0] idx,
                         input logic [WD:0] exp);
        d_in = mkd(1'b0, 1'b0, idx, 8'h00);
        #1;
        check(name, q_out, exp);
        d_in = '0;
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        tick(4);
        scl_m = 1'b1;
        tick(8);
        sda_m = 1'b0;
        tick(8);
        scl_m = 1'b0;
        tick(4);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        tick(4);
        scl_m = 1'b1;
        tick(8);
        sda_m = 1'b1;
        tick(8);
    endtask

    // inject != 0: core word driven in the cycle the 8th bit is committed
    task automatic send_byte(input logic [7:0] b, input logic exp_ack,
                             input string name, input logic [WD:0] inject);
        logic drove;
        drove = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sda_m = b[7-i];
            tick(4);
            scl_m = 1'b1;
            if (i == 7 && inject != '0) begin
                tick(2);
                d_in = inject;
                tick(1);
                d_in = '0;
                tick(1);
            end else begin
                tick(4);
            end
            drove = drove | sda_oe_out;
            tick(4);
            scl_m = 1'b0;
            tick(4);
        end
        check({name, "_nodrive"}, {32'd0, drove}, '0);
        sda_m = 1'b1;
        tick(4);
        scl_m = 1'b1;
        tick(4);
        check({name, "_ack"}, {32'd0, sda_oe_out}, {32'd0, exp_ack});
        tick(4);
        scl_m = 1'b0;
        tick(4);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1;
            tick(4);
            scl_m = 1'b1;
            tick(4);
            b[7-i] = sda_bus;
            tick(4);
            scl_m = 1'b0;
            tick(4);
        end
        sda_m = ~ack;
        tick(4);
        scl_m = 1'b1;
        tick(8);
        scl_m = 1'b0;
        tick(4);
        sda_m = 1'b1;
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        rst_n_in = 1'b0;
        scl_m    = 1'b1;
        sda_m    = 1'b1;
        d_in     = '0;

        tbl[0] = '{1'b1, 1'b0, 4'd1,  8'h3C, mkq(0, 0, 0, 8'h00)};
        tbl[1] = '{1'b0, 1'b0, 4'd1,  8'h00, mkq(0, 0, 0, 8'h3C)};
        tbl[2] = '{1'b1, 1'b0, 4'd7,  8'hC3, mkq(0, 0, 0, 8'h00)};
        tbl[3] = '{1'b0, 1'b0, 4'd7,  8'h00, mkq(0, 0, 0, 8'hC3)};
        tbl[4] = '{1'b1, 1'b0, 4'd15, 8'hFF, mkq(0, 0, 0, 8'h00)};
        tbl[5] = '{1'b0, 1'b0, 4'd15, 8'h00, mkq(0, 0, 0, 8'hFF)};
        tbl[6] = '{1'b0, 1'b1, 4'd2,  8'h00, mkq(0, 0, 0, 8'h00)};
        tbl[7] = '{1'b0, 1'b0, 4'd1,  8'h00, mkq(0, 0, 0, 8'h3C)};
        tbl[8] = '{1'b1, 1'b0, 4'd2,  8'h81, mkq(0, 0, 0, 8'h00)};
        tbl[9] = '{1'b0, 1'b0, 4'd2,  8'h00, mkq(0, 0, 0, 8'h81)};

        tick(4);
        rst_n_in = 1'b1;
        tick(2);
        check("reset_oe", {32'd0, sda_oe_out}, '0);
        chk_q("reset_q", 4'd0, '0);

        // reset while driving a 0 bit of a read
        bus_start();
        send_byte(8'h85, 1'b1, "t1_addr", '0);
        check("t1_rd_drive", {32'd0, sda_oe_out}, {32'd0, 1'b1});
        rst_n_in = 1'b0;
        tick(1);
        check("t1_rst_release", {32'd0, sda_oe_out}, '0);
        chk_q("t1_rst_idle", 4'd0, '0);
        rst_n_in = 1'b1;
        bus_stop();

        for (int i = 0; i < 10; i++) begin
            d_in = mkd(tbl[i].we, tbl[i].clr, tbl[i].idx, tbl[i].data);
            #1;
            check($sformatf("vec%0d", i), q_out, tbl[i].exp_q);
            tick(1);
        end
        d_in = '0;

        bus_start();
        send_byte(8'h84, 1'b1, "t2_addr", '0);
        send_byte(8'h03, 1'b1, "t2_ptr", '0);
        send_byte(8'hA5, 1'b1, "t2_d0", '0);
        chk_q("t2_busy", 4'd3, mkq(1, 1, 4'd4, 8'hA5));
        send_byte(8'h5A, 1'b1, "t2_d1", '0);
        bus_stop();
        chk_q("t2_reg3", 4'd3, mkq(0, 1, 4'd5, 8'hA5));
        chk_q("t2_reg4", 4'd4, mkq(0, 1, 4'd5, 8'h5A));
        d_in = mkd(1'b0, 1'b1, 4'd0, 8'h00);
        tick(1);
        chk_q("t2_clear", 4'd4, mkq(0, 0, 4'd5, 8'h5A));

        bus_start();
        send_byte(8'h84, 1'b1, "t3_addr", '0);
        send_byte(8'h0F, 1'b1, "t3_ptr", '0);
        send_byte(8'h11, 1'b1, "t3_d0", '0);
        send_byte(8'h22, 1'b1, "t3_d1", '0);
        bus_stop();
        chk_q("t3_reg15", 4'd15, mkq(0, 1, 4'd1, 8'h11));
        chk_q("t3_reg0", 4'd0, mkq(0, 1, 4'd1, 8'h22));

        bus_start();
        send_byte(8'h84, 1'b1, "t4_addr", '0);
        send_byte(8'h0F, 1'b1, "t4_ptr", '0);
        bus_start();
        send_byte(8'h85, 1'b1, "t4_raddr", '0);
        recv_byte(1'b1, rd);
        check("t4_rd0", {25'd0, rd}, {25'd0, 8'h11});
        recv_byte(1'b0, rd);
        check("t4_rd1", {25'd0, rd}, {25'd0, 8'h22});
        chk_q("t4_wait", 4'd0, mkq(0, 1, 4'd1, 8'h22));
        send_byte(8'h00, 1'b0, "t4_ignored", '0);
        bus_stop();
        chk_q("t4_after", 4'd15, mkq(0, 1, 4'd1, 8'h11));

        bus_start();
        send_byte(8'h90, 1'b0, "t5_addr", '0);
        send_byte(8'h04, 1'b0, "t5_b0", '0);
        send_byte(8'h34, 1'b0, "t5_b1", '0);
        bus_stop();
        chk_q("t5_reg4", 4'd4, mkq(0, 1, 4'd1, 8'h5A));
        chk_q("t5_reg0", 4'd0, mkq(0, 1, 4'd1, 8'h22));

        d_in = mkd(1'b0, 1'b1, 4'd0, 8'h00);
        tick(1);
        chk_q("t6_cleared", 4'd4, mkq(0, 0, 4'd1, 8'h5A));
        bus_start();
        send_byte(8'h84, 1'b1, "t6_addr", '0);
        send_byte(8'h04, 1'b1, "t6_ptr", '0);
        send_byte(8'h5A, 1'b1, "t6_d0", mkd(1'b1, 1'b1, 4'd4, 8'h77));
        bus_stop();
        chk_q("t6_conflict", 4'd4, mkq(0, 1, 4'd5, 8'h77));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
